pfd_loop_filter: RTL

- Digital loop filter downstream of the phase-frequency detector (PFD).
- Measures the width of the PFD's XOR `phase_signal` pulse in fast-`clk` cycles over each reference period.
- Compares the width against a target and runs a saturating proportional-integral (PI) update.
- Emits a control word for the oscillator/divider stage, plus a lock indicator.

---
 rtl/pfd_loop_filter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pfd_loop_filter.sv
// -----------------------------------------------------------------------------
// pfd_loop_filter
//
// Digital PI loop filter sitting behind a phase-frequency detector. The PFD's
// XOR pulse (phase_signal) is measured in clk cycles over each reference
// period, delimited by rising edges of ref_clk. The measured width is compared
// against TARGET and drives a saturating proportional-integral update of the
// oscillator/divider control word. A lock flag is raised after LOCK_COUNT
// consecutive windows inside +/-LOCK_TOL with no counter saturation.
//
// Ports:
//   clk          in   fast sampling clock
//   rstn         in   asynchronous active-low reset
//   enable       in   loop enable (synchronous to clk)
//   phase_signal in   PFD pulse, asynchronous to clk
//   ref_clk      in   reference clock, asynchronous to clk; rising edges
//                     delimit measurement windows
//   ctrl_init    in   starting control word, held stable while enable=1
//   ctrl_word    out  control word for the oscillator/divider stage
//   ctrl_valid   out  one-cycle strobe on each ctrl_word update
//   width_out    out  last published pulse width
//   overflow     out  last published window saturated the width counter
//   lock         out  loop locked
//
// Latency, with the synchronized ref edge seen in cycle E:
//   E+1 width_out/overflow, E+2 error, E+3 ctrl_word + ctrl_valid.
// -----------------------------------------------------------------------------
module pfd_loop_filter #(
    parameter int CNT_W       = 12,
    parameter int CTRL_W      = 16,
    parameter int TARGET      = 0,
    parameter int KP_SHIFT    = 2,
    parameter int KI_SHIFT    = 6,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              phase_signal,
    input  logic              ref_clk,
    input  logic [CTRL_W-1:0] ctrl_init,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              ctrl_valid,
    output logic [CNT_W-1:0]  width_out,
    output logic              overflow,
    output logic              lock
);

    // Sum width: enough headroom that ctrl_init + integrator + proportional
    // term never wraps before clamping.
    localparam int SUM_W = ((CTRL_W > CNT_W) ? CTRL_W : CNT_W) + 4;
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]        CNT_MAX    = '1;
    localparam logic signed [CNT_W:0]   TARGET_S   = (CNT_W+1)'(TARGET);
    localparam logic [CNT_W:0]          LOCK_TOL_U = (CNT_W+1)'(LOCK_TOL);
    localparam logic [LCK_W-1:0]        LOCK_FULL  = LCK_W'(LOCK_COUNT);
    localparam logic signed [SUM_W-1:0] INTEG_MAX  = (SUM_W'(1) <<< CTRL_W) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] INTEG_MIN  = -(SUM_W'(1) <<< CTRL_W);
    localparam logic signed [SUM_W-1:0] CTRL_MAX   = (SUM_W'(1) <<< CTRL_W) - SUM_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    // Integrator saturation to the signed CTRL_W+1 range.
    function automatic logic signed [CTRL_W:0] sat_integ(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] y;
        if (x > INTEG_MAX) begin
            y = INTEG_MAX;
        end else if (x < INTEG_MIN) begin
            y = INTEG_MIN;
        end else begin
            y = x;
        end
        return y[CTRL_W:0];
    endfunction

    // Output clamp to the unsigned control word range.
    function automatic logic [CTRL_W-1:0] clamp_ctrl(input logic signed [SUM_W-1:0] x);
        logic [CTRL_W-1:0] y;
        if (x[SUM_W-1]) begin
            y = '0;
        end else if (x > CTRL_MAX) begin
            y = '1;
        end else begin
            y = x[CTRL_W-1:0];
        end
        return y;
    endfunction

    logic [SYNC_STAGES-1:0] ph_sync;
    logic [SYNC_STAGES-1:0] ref_sync;
    logic                   ref_prev;
    logic                   ph_s;
    logic                   ref_s;
    logic                   ref_edge;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   sat;

    logic [CNT_W-1:0]       width_p0;
    logic                   sat_p0;
    logic                   vld_p0;

    logic signed [CNT_W:0]  err_p1;
    logic                   ovf_p1;
    logic                   vld_p1;

    logic signed [CTRL_W:0] integ;
    logic [LCK_W-1:0]       lock_cnt;

    logic signed [SUM_W-1:0] err_w;
    logic signed [SUM_W-1:0] integ_sum;
    logic signed [CTRL_W:0]  integ_next;
    logic signed [SUM_W-1:0] ctrl_sum;
    logic [CTRL_W-1:0]       ctrl_next;
    logic [CNT_W:0]          err_abs;
    logic                    in_tol;
    logic [LCK_W-1:0]        lock_cnt_next;

    // Synchronizers for the two asynchronous inputs; both share the same
    // depth so pulse and window edges stay aligned in the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_sync  <= '0;
            ref_sync <= '0;
            ref_prev <= 1'b0;
        end else begin
            ph_sync  <= {ph_sync[SYNC_STAGES-2:0], phase_signal};
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_clk};
            ref_prev <= ref_sync[SYNC_STAGES-1];
        end
    end

    assign ph_s     = ph_sync[SYNC_STAGES-1];
    assign ref_s    = ref_sync[SYNC_STAGES-1];
    assign ref_edge = ref_s & ~ref_prev;

    // Stage p0: window FSM, width counter and capture of the finished window.
    // The sample taken in the edge cycle already belongs to the new window.
    // A closer-spaced edge simply overwrites the capture registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            sat      <= 1'b0;
            width_p0 <= '0;
            sat_p0   <= 1'b0;
            vld_p0   <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            cnt    <= '0;
            sat    <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    state <= ACQUIRE;
                    cnt   <= '0;
                    sat   <= 1'b0;
                end
                ACQUIRE, TRACK: begin
                    if (ref_edge) begin
                        cnt <= {{(CNT_W-1){1'b0}}, ph_s};
                        sat <= 1'b0;
                        // The window closed in ACQUIRE started mid-period,
                        // so it is dropped rather than published.
                        if (state == TRACK) begin
                            width_p0 <= cnt;
                            sat_p0   <= sat;
                            vld_p0   <= 1'b1;
                        end
                        state <= TRACK;
                    end else if (ph_s) begin
                        if (cnt == CNT_MAX) begin
                            sat <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign width_out = width_p0;
    assign overflow  = sat_p0;

    // Stage p1: signed phase error against the target width.
    always_ff @(posedge clk) begin
        err_p1 <= $signed({1'b0, width_p0}) - TARGET_S;
        ovf_p1 <= sat_p0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 & enable;
        end
    end

    always_comb begin
        err_w         = SUM_W'(err_p1);
        integ_sum     = SUM_W'(integ) + (err_w >>> KI_SHIFT);
        integ_next    = sat_integ(integ_sum);
        ctrl_sum      = SUM_W'($signed({1'b0, ctrl_init})) + SUM_W'(integ_next)
                        + (err_w >>> KP_SHIFT);
        ctrl_next     = clamp_ctrl(ctrl_sum);
        err_abs       = err_p1[CNT_W] ? $unsigned(-err_p1) : $unsigned(err_p1);
        in_tol        = (err_abs <= LOCK_TOL_U) && !ovf_p1;
        lock_cnt_next = '0;
        if (in_tol) begin
            lock_cnt_next = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LCK_W'(1);
        end
    end

    // Stage p2: PI state, control word, strobe and lock tracking. Leaving
    // the loop (or sitting in IDLE) parks the word at ctrl_init and drops
    // anything still in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_word  <= '0;
            ctrl_valid <= 1'b0;
            integ      <= '0;
            lock_cnt   <= '0;
            lock       <= 1'b0;
        end else if (!enable || state == IDLE) begin
            ctrl_word  <= ctrl_init;
            ctrl_valid <= 1'b0;
            integ      <= '0;
            lock_cnt   <= '0;
            lock       <= 1'b0;
        end else begin
            ctrl_valid <= vld_p1;
            if (vld_p1) begin
                integ     <= integ_next;
                ctrl_word <= ctrl_next;
                lock_cnt  <= lock_cnt_next;
                lock      <= (lock_cnt_next == LOCK_FULL);
            end
        end
    end

endmodule
